// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the Gray-counter frequency meter.
// gray2bin works at the default width; narrower counters are zero-extended by the caller.
package freq_meter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } fm_state_t;

    // Zero-extending a narrower Gray value leaves its low bits decoding identically.
    function automatic logic [CNT_W_DEFAULT-1:0] gray2bin(
        input logic [CNT_W_DEFAULT-1:0] gray
    );
        logic [CNT_W_DEFAULT-1:0] bin;
        bin[CNT_W_DEFAULT-1] = gray[CNT_W_DEFAULT-1];
        for (int i = CNT_W_DEFAULT - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Two-flop synchronizer for a foreign-domain Gray counter, followed by a registered
// Gray-to-binary decode. Reusable by any CDC counter reader.
module gray_sync
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_100MHz_i,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] gray_i,
    output logic [CNT_W-1:0] bin_o
);

    logic [CNT_W-1:0]         sync1_q;
    logic [CNT_W-1:0]         sync2_q;
    logic [CNT_W_DEFAULT-1:0] gray_ext;
    logic [CNT_W_DEFAULT-1:0] bin_ext;

    always_comb begin
        gray_ext              = '0;
        gray_ext[CNT_W-1:0]   = sync2_q;
        bin_ext               = gray2bin(gray_ext);
    end

    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            bin_o   <= '0;
        end else begin
            sync1_q <= gray_i;
            sync2_q <= sync1_q;
            bin_o   <= bin_ext[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/gray_freq_meter.sv
// Counts increments of a synchronized Gray counter over a fixed gate window and
// publishes the saturated per-window count with a one-cycle valid pulse.
module gray_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned GATE_CYCLES = 100000
) (
    input  logic             clk_100MHz_i,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] gray_i,
    output logic [CNT_W-1:0] freq_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam int unsigned     GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W:0]  ACC_MAX   = {1'b0, {CNT_W{1'b1}}};

    fm_state_t         state_q;
    logic [CNT_W-1:0]  bin_q;
    logic [CNT_W-1:0]  bin_prev_q;
    logic [CNT_W-1:0]  step;
    logic [CNT_W:0]    acc_q;
    logic [CNT_W:0]    acc_sum;
    logic [CNT_W:0]    acc_next;
    logic              sat_q;
    logic              sat_next;
    logic [GATE_W-1:0] gate_q;

    gray_sync #(
        .CNT_W(CNT_W)
    ) u_gray_sync (
        .clk_100MHz_i(clk_100MHz_i),
        .rst_n       (rst_n),
        .gray_i      (gray_i),
        .bin_o       (bin_q)
    );

    // Modular subtraction turns a source wrap (all-ones to 0) into an ordinary step of 1.
    always_comb begin
        step     = bin_q - bin_prev_q;
        acc_sum  = acc_q + {1'b0, step};
        sat_next = sat_q | (acc_sum > ACC_MAX);
        acc_next = (acc_sum > ACC_MAX) ? ACC_MAX : acc_sum;
    end

    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_prev_q <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            gate_q     <= '0;
            freq_o     <= '0;
            valid_o    <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            bin_prev_q <= bin_q;
            valid_o    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en_i) state_q <= ARM;
                end
                ARM: begin
                    acc_q   <= '0;
                    gate_q  <= '0;
                    sat_q   <= 1'b0;
                    state_q <= MEASURE;
                end
                MEASURE: begin
                    // Dropping enable wins over the terminal cycle; the window is discarded.
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (gate_q == GATE_LAST) begin
                        freq_o  <= sat_next ? '1 : acc_next[CNT_W-1:0];
                        ovf_o   <= sat_next;
                        valid_o <= 1'b1;
                        acc_q   <= '0;
                        gate_q  <= '0;
                        sat_q   <= 1'b0;
                    end else begin
                        gate_q  <= gate_q + 1'b1;
                        acc_q   <= acc_next;
                        sat_q   <= sat_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_freq_meter.sv
// Randomized bench for gray_freq_meter: an 8-bit and a 4-bit meter share one source
// counter and are compared every cycle against a window-counting reference model.
module tb_gray_freq_meter;

    localparam int unsigned G = 100;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] gray8;
    logic [3:0] gray4;
    logic [7:0] freq8;
    logic [3:0] freq4;
    logic       valid8, valid4, ovf8, ovf4;

    // Source counter (free-running, foreign domain)
    logic [31:0] src_val;
    logic [7:0]  low8;
    logic [3:0]  low4;
    int          src_period;
    bit          jitter;
    int          load_cnt;
    logic [31:0] load_val;

    assign low8  = src_val[7:0];
    assign low4  = src_val[3:0];
    assign gray8 = low8 ^ {1'b0, low8[7:1]};
    assign gray4 = low4 ^ {1'b0, low4[3:1]};

    // Reference model state
    int         h[4];
    int         m_mode;
    int         m_gate;
    int         tot8, tot4, s8, s4;
    bit         e_valid;
    logic [7:0] e_freq8;
    logic [3:0] e_freq4;
    bit         e_ovf8, e_ovf4;

    int n_chk;
    int n_fail;

    gray_freq_meter #(
        .CNT_W      (8),
        .GATE_CYCLES(G)
    ) dut8 (
        .clk_100MHz_i(clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .gray_i      (gray8),
        .freq_o      (freq8),
        .valid_o     (valid8),
        .ovf_o       (ovf8)
    );

    gray_freq_meter #(
        .CNT_W      (4),
        .GATE_CYCLES(G)
    ) dut4 (
        .clk_100MHz_i(clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .gray_i      (gray4),
        .freq_o      (freq4),
        .valid_o     (valid4),
        .ovf_o       (ovf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source: one increment every src_period cycles (random gap >= 2 when jittering).
    initial begin
        int since;
        int gap;
        int last_load;
        since = 0;
        gap = 2;
        last_load = 0;
        forever begin
            @(posedge clk);
            #1;
            if (load_cnt != last_load) begin
                last_load = load_cnt;
                src_val   = load_val;
                since     = 0;
            end else if (src_period != 0) begin
                since++;
                if (since >= gap) begin
                    src_val = src_val + 1;
                    since   = 0;
                    gap     = jitter ? int'($urandom_range(2, src_period)) : src_period;
                end
            end
        end
    end

    // Model: a window is 100 enabled cycles after a one-cycle arm; its result is the number
    // of source increments seen 3 cycles late, clamped to each meter's full scale.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode  = 0;
                m_gate  = 0;
                tot8    = 0;
                tot4    = 0;
                for (int i = 0; i < 4; i++) h[i] = 0;
                e_valid = 1'b0;
                e_freq8 = '0;
                e_freq4 = '0;
                e_ovf8  = 1'b0;
                e_ovf4  = 1'b0;
            end else begin
                s8 = (h[2] - h[3]) & 255;
                s4 = (h[2] - h[3]) & 15;
                e_valid = 1'b0;
                if (m_mode == 0) begin
                    if (en) m_mode = 1;
                end else if (m_mode == 1) begin
                    tot8   = 0;
                    tot4   = 0;
                    m_gate = 0;
                    m_mode = 2;
                end else if (!en) begin
                    m_mode = 0;
                end else begin
                    tot8 += s8;
                    tot4 += s4;
                    if (m_gate == G - 1) begin
                        e_valid = 1'b1;
                        e_freq8 = (tot8 > 255) ? 8'hff : 8'(tot8);
                        e_ovf8  = (tot8 > 255);
                        e_freq4 = (tot4 > 15) ? 4'hf : 4'(tot4);
                        e_ovf4  = (tot4 > 15);
                        tot8    = 0;
                        tot4    = 0;
                        m_gate  = 0;
                    end else begin
                        m_gate++;
                    end
                end
                h[3] = h[2];
                h[2] = h[1];
                h[1] = h[0];
                h[0] = int'(src_val);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            n_chk++;
            if (valid8 !== e_valid || valid4 !== e_valid || freq8 !== e_freq8 ||
                ovf8 !== e_ovf8 || freq4 !== e_freq4 || ovf4 !== e_ovf4) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got v=%b/%b f8=%0d o8=%b f4=%0d o4=%b, exp v=%b f8=%0d o8=%b f4=%0d o4=%b",
                         $time, valid8, valid4, freq8, ovf8, freq4, ovf4,
                         e_valid, e_freq8, e_ovf8, e_freq4, e_ovf4);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Edges until valid8 is seen (sampled 1 time unit after each edge), bounded by maxc.
    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid8 && n < maxc);
    endtask

    task automatic count_valids(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (valid8 || valid4) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        src_val    = '0;
        src_period = 3;
        jitter     = 1'b0;
        load_cnt   = 0;
        load_val   = '0;

        // Reset held with the source toggling, then idle with enable low
        repeat (20) @(posedge clk);
        #1;
        chk("reset_freq8", int'(freq8), 0);
        chk("reset_valid8", int'(valid8), 0);
        chk("reset_ovf8", int'(ovf8), 0);
        rst_n = 1'b1;
        count_valids(500, cnt);
        chk("idle_no_valid", cnt, 0);

        // Steady rate: one increment per 4 cycles
        src_period = 4;
        en = 1'b1;
        wait_valid(150, n);
        chk("first_valid_latency", n, 102);
        chk_near("steady_freq8", int'(freq8), 25, 1);
        chk("steady_ovf8", int'(ovf8), 0);
        wait_valid(150, n);
        chk("valid_period", n, 100);
        chk_near("steady_freq8_2", int'(freq8), 25, 1);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", int'(valid8), 0);

        // Source wrap through 255 -> 0 at one increment per 2 cycles
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        load_val = 32'd250;
        load_cnt++;
        src_period = 2;
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;
        wait_valid(150, n);
        chk("wrap_latency", n, 102);
        chk_near("wrap_freq8", int'(freq8), 50, 1);
        chk("wrap_ovf8", int'(ovf8), 0);
        // Same window on the 4-bit meter saturates
        chk("sat_freq4", int'(freq4), 15);
        chk("sat_ovf4", int'(ovf4), 1);

        // Slow the source; the fully slow window must clear the overflow
        src_period = 10;
        wait_valid(150, n);
        chk("slow_period_a", n, 100);
        wait_valid(150, n);
        chk("slow_period_b", n, 100);
        chk_near("slow_freq4", int'(freq4), 10, 1);
        chk("slow_ovf4", int'(ovf4), 0);

        // Abort at gate 60: no pulse, outputs held, then a full restart
        repeat (60) @(posedge clk);
        #1;
        en = 1'b0;
        count_valids(150, cnt);
        chk("abort_no_valid", cnt, 0);
        chk_near("abort_hold_freq8", int'(freq8), 10, 1);
        en = 1'b1;
        wait_valid(150, n);
        chk("reenable_latency", n, 102);

        // Asynchronous reset mid-window, asserted away from the clock edge
        repeat (41) @(posedge clk);
        #4;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("areset_freq8", int'(freq8), 0);
        chk("areset_ovf8", int'(ovf8), 0);
        chk("areset_freq4", int'(freq4), 0);
        chk("areset_valid8", int'(valid8), 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_valids(200, cnt);
        chk("post_reset_no_valid", cnt, 0);
        en = 1'b1;
        wait_valid(150, n);
        chk("post_reset_latency", n, 102);

        // Random source jitter and random enable segments, checked by the model
        jitter = 1'b1;
        for (int seg = 0; seg < 14; seg++) begin
            src_period = int'($urandom_range(2, 12));
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(50, 400)) @(posedge clk);
            #1;
        end
        en = 1'b1;
        src_period = 3;
        repeat (250) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
